edge_log_ctrl: RTL and testbench

- Raster-scan sequencer for the combinational 5x5 Laplacian-of-Gaussian kernel (edge_LOG).
- Accepts a streamed 8-bit greyscale frame, keeps 4 line buffers plus a 5x5 window register, and presents each complete window to the kernel on a 200-bit bus.
- Captures the kernel result and streams it out with valid/ready backpressure.
- Only interior pixels are emitted: (IMG_W-4)*(IMG_H-4) results per frame. Sits between the JPEG decoder pixel output and the edge-map sink.

---
 rtl/edge_log_pkg.sv | 21 ++
 rtl/edge_log_linebuf.sv | 33 +++
 rtl/edge_log_ctrl.sv | 152 +++++++++++++++
 tb/tb_edge_log_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_log_pkg.sv
// Shared constants, FSM state encoding and window bit-offset helper for the
// edge_LOG raster-scan sequencer.
package edge_log_pkg;

   localparam int KSIZE = 5;
   localparam int PIX_W = 8;
   localparam int WIN_W = KSIZE * KSIZE * PIX_W;
   localparam int NTAPS = KSIZE - 1;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;

   // Bit offset of window element (row, col); row 0 is the oldest line.
   function automatic int win_idx(input int row, input int col);
      return (KSIZE * row + col) * PIX_W;
   endfunction

endpackage

// File: rtl/edge_log_linebuf.sv
// Four IMG_W-deep line buffers that shift vertically at the addressed column;
// tap 0 is the oldest stored line, tap NTAPS-1 the line just above the input.
module edge_log_linebuf
   import edge_log_pkg::*;
#(
   parameter int IMG_W = 64
) (
   input  logic                         clk,
   input  logic [$clog2(IMG_W)-1:0]     addr,
   input  logic                         wr_en,
   input  logic [PIX_W-1:0]             wr_data,
   output logic [NTAPS-1:0][PIX_W-1:0]  taps
);

   logic [PIX_W-1:0] mem [NTAPS][IMG_W];

   // NOTE: storage is not reset; only lines written during the current frame are ever qualified into a result.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < NTAPS - 1; i++) begin
            mem[i][addr] <= mem[i+1][addr];
         end
         mem[NTAPS-1][addr] <= wr_data;
      end
   end

   always_comb begin
      for (int i = 0; i < NTAPS; i++) begin
         taps[i] = mem[i][addr];
      end
   end

endmodule

// File: rtl/edge_log_ctrl.sv
// Raster-scan sequencer feeding a 5x5 window to the external edge_LOG kernel
// and streaming interior results out. Optional EDGE_LOG_THRESH_EN adds a
// binary threshold on the kernel result.
module edge_log_ctrl
   import edge_log_pkg::*;
#(
   parameter int IMG_W = 64,
   parameter int IMG_H = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [7:0]         s_data,
   input  logic               s_valid,
   output logic               s_ready,
   output logic [WIN_W-1:0]   win_out,
   input  logic [7:0]         kernel_pix,
`ifdef EDGE_LOG_THRESH_EN
   input  logic [7:0]         thresh,
`endif
   output logic [7:0]         m_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic               busy,
   output logic               done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_WIN0 = CW'(KSIZE - 1);
   localparam logic [RW-1:0] ROW_WIN0 = RW'(KSIZE - 1);

   state_t                      state;
   logic [CW-1:0]               col;
   logic [RW-1:0]               row;
   logic [PIX_W-1:0]            win [KSIZE][KSIZE];
   logic                        win_vld;
   logic [NTAPS-1:0][PIX_W-1:0] taps;
   logic                        advance;
   logic                        accept;
   logic                        last_pix;
   logic                        drain_done;
   logic [PIX_W-1:0]            result;

   assign advance    = !m_valid || m_ready;
   assign s_ready    = (state == ST_RUN) && advance;
   assign accept     = s_valid && s_ready;
   assign last_pix   = (row == ROW_LAST) && (col == COL_LAST);
   assign drain_done = (state == ST_DRAIN) && !win_vld && advance;
   assign busy       = (state != ST_IDLE);

`ifdef EDGE_LOG_THRESH_EN
   assign result = (kernel_pix >= thresh) ? 8'hFF : 8'h00;
`else
   assign result = kernel_pix;
`endif

   edge_log_linebuf #(
      .IMG_W (IMG_W)
   ) u_linebuf (
      .clk     (clk),
      .addr    (col),
      .wr_en   (accept),
      .wr_data (s_data),
      .taps    (taps)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         row   <= '0;
         col   <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_RUN;
                  row   <= '0;
                  col   <= '0;
               end
            end
            ST_RUN: begin
               if (accept && last_pix) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (drain_done) begin
                  state <= ST_IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase

         if (accept) begin
            if (col == COL_LAST) begin
               col <= '0;
               row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   // A new accept re-arms win_vld in the same edge that stage 2 consumes the old one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
               win[r][c] <= '0;
            end
         end
         win_vld <= 1'b0;
         m_valid <= 1'b0;
         m_data  <= '0;
      end else begin
         if (advance) begin
            m_valid <= win_vld;
            if (win_vld) m_data <= result;
            win_vld <= 1'b0;
         end
         if (accept) begin
            for (int r = 0; r < KSIZE; r++) begin
               for (int c = 0; c < KSIZE - 1; c++) begin
                  win[r][c] <= win[r][c+1];
               end
            end
            for (int r = 0; r < NTAPS; r++) begin
               win[r][KSIZE-1] <= taps[r];
            end
            win[KSIZE-1][KSIZE-1] <= s_data;
            win_vld <= (row >= ROW_WIN0) && (col >= COL_WIN0);
         end
      end
   end

   // NOTE: the default assignment keeps this combinational block free of inferred latches.
   always_comb begin
      win_out = '0;
      for (int r = 0; r < KSIZE; r++) begin
         for (int c = 0; c < KSIZE; c++) begin
            win_out[win_idx(r, c) +: PIX_W] = win[r][c];
         end
      end
   end

endmodule

// File: tb/tb_edge_log_ctrl.sv
// Self-checking bench for edge_log_ctrl on an 8x8 frame: emulates an asymmetric
// 5x5 kernel on win_out and compares the output stream with a frame-level model.
`timescale 1ns/1ps
module tb_edge_log_ctrl;

   localparam int W    = 8;
   localparam int H    = 8;
   localparam int NPIX = W * H;
   localparam int NOUT = (W - 4) * (H - 4);

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [7:0]   s_data = '0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [199:0] win_out;
   logic [7:0]   kernel_pix;
   logic [7:0]   m_data;
   logic         m_valid;
   logic         m_ready = 1'b0;
   logic         busy;
   logic         done;
`ifdef EDGE_LOG_THRESH_EN
   logic [7:0]   thresh = 8'h10;
`endif

   int         checks = 0;
   int         failures = 0;
   int         ready_pct = 100;
   int         done_cnt = 0;
   int         kacc;
   bit         last_acc = 1'b0;
   bit         prev_stall = 1'b0;
   logic [7:0] prev_data = '0;
   logic [7:0] img [NPIX];
   logic [7:0] exp_q [$];
   logic [7:0] got_q [$];

   edge_log_ctrl #(
      .IMG_W (W),
      .IMG_H (H)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .win_out    (win_out),
      .kernel_pix (kernel_pix),
`ifdef EDGE_LOG_THRESH_EN
      .thresh     (thresh),
`endif
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Deliberately asymmetric weights (sum 1) so row/column orientation errors show.
   function automatic int wgt(input int dr, input int dc);
      if (dr ==  0 && dc ==  0) return 21;
      if (dr == -1 && dc ==  0) return -1;
      if (dr ==  1 && dc ==  0) return -2;
      if (dr ==  0 && dc == -1) return -3;
      if (dr ==  0 && dc ==  1) return -4;
      if (dr == -2 && dc ==  0) return -2;
      if (dr ==  2 && dc ==  0) return -3;
      if (dr ==  0 && dc == -2) return -4;
      if (dr ==  0 && dc ==  2) return -1;
      return 0;
   endfunction

   function automatic logic [7:0] post(input logic [7:0] v);
`ifdef EDGE_LOG_THRESH_EN
      return (v >= thresh) ? 8'hFF : 8'h00;
`else
      return v;
`endif
   endfunction

   // Result for the window centred on frame pixel (cr, cc).
   function automatic logic [7:0] model_pix(input int cr, input int cc);
      int acc = 0;
      for (int dr = -2; dr <= 2; dr++) begin
         for (int dc = -2; dc <= 2; dc++) begin
            acc += wgt(dr, dc) * int'(img[(cr + dr) * W + (cc + dc)]);
         end
      end
      return post(acc[7:0]);
   endfunction

   // Stand-in for the external combinational kernel.
   always_comb begin
      kacc = 0;
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < 5; j++) begin
            kacc += wgt(i - 2, j - 2) * int'(win_out[(5 * i + j) * 8 +: 8]);
         end
      end
      kernel_pix = kacc[7:0];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         m_ready = ($urandom_range(99) < ready_pct);
      end
   end

   // Compare process: outputs are sampled mid-cycle, a handshake completes at the next edge.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         last_acc = s_valid && s_ready;
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (done) done_cnt++;
            if (m_valid && !m_ready) check("stall_s_ready", s_ready, 0);
            if (prev_stall) begin
               check("stall_hold_valid", m_valid, 1);
               check("stall_hold_data", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
               got_q.push_back(m_data);
               if (exp_q.size() == 0) check("unexpected_output", m_valid, 0);
               else check("m_data", m_data, exp_q.pop_front());
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
         end
      end
   end

   task automatic fill_frame(input int mode);
      for (int i = 0; i < NPIX; i++) begin
         case (mode)
            0:       img[i] = 8'd10;
            1:       img[i] = (i == 4 * W + 4) ? 8'd1 : 8'd0;
            default: img[i] = 8'($urandom_range(255));
         endcase
      end
      exp_q.delete();
      for (int r = 4; r < H; r++) begin
         for (int c = 4; c < W; c++) begin
            exp_q.push_back(model_pix(r - 2, c - 2));
         end
      end
   endtask

   task automatic run_frame(input int mode, input int vpct, input int rpct, input int abort_at);
      int idx;
      int cyc;
      bit poked;
      fill_frame(mode);
      got_q.delete();
      done_cnt  = 0;
      ready_pct = rpct;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
      idx   = 0;
      cyc   = 0;
      poked = 1'b0;
      forever begin
         if (last_acc) idx++;
         if (idx == NPIX || cyc >= 4000) break;
         if (abort_at > 0 && idx == abort_at) break;
         s_valid = ($urandom_range(99) < vpct);
         s_data  = img[idx];
         start   = (idx == 20) && !poked;
         if (start) poked = 1'b1;
         @(negedge clk);
         cyc++;
      end
      s_valid = 1'b0;
      start   = 1'b0;
      if (abort_at > 0 && idx == abort_at) begin
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         exp_q.delete();
         @(negedge clk);
         #3;
         check("abort_busy", busy, 0);
         check("abort_m_valid", m_valid, 0);
         check("abort_s_ready", s_ready, 0);
         check("abort_no_output", got_q.size(), 0);
         return;
      end
      check("feed_complete", idx, NPIX);
      check("busy_in_drain", busy, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (busy && cyc < 4000) begin
         @(negedge clk);
         cyc++;
      end
      check("drain_timeout", busy, 0);
      repeat (4) @(negedge clk);
      #3;
      check("done_pulses", done_cnt, 1);
      check("out_count", got_q.size(), NOUT);
      check("exp_left", exp_q.size(), 0);
      check("idle_after_frame", busy, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #3;
      check("rst_s_ready", s_ready, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_win_out", {31'b0, |win_out}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Constant frame: sum of weights is 1, so every output is the pixel value.
      run_frame(0, 100, 100, 0);
      for (int i = 0; i < got_q.size(); i++) check("const_val", got_q[i], post(8'h0A));

      // Impulse of 1 at (4,4): hand-computed weights at the offsets seen by each window.
      run_frame(1, 100, 100, 0);
      if (got_q.size() == NOUT) begin
         check("imp_centre", got_q[10], post(8'h15));
         check("imp_above",  got_q[6],  post(8'hFE));
         check("imp_left",   got_q[9],  post(8'hFC));
         check("imp_above2", got_q[2],  post(8'hFD));
         check("imp_below",  got_q[14], post(8'hFF));
         check("imp_corner", got_q[0],  post(8'h00));
      end

      run_frame(2, 70, 50, 0);
      run_frame(2, 90, 50, 0);
      run_frame(1, 80, 40, 0);

      // Abort after 30 pixels, then a clean constant frame must show no residue.
      run_frame(0, 100, 100, 30);
      run_frame(0, 100, 100, 0);
      for (int i = 0; i < got_q.size(); i++) check("post_abort_val", got_q[i], post(8'h0A));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
